// File: rtl/umi_req_arbiter_if.sv
// Bundles the host-side and device-side UMI request/response channels of the arbiter.
// slave is the arbiter view; master is the surrounding system (hosts plus device).
interface umi_req_arbiter_if #(
    parameter int N  = 2,
    parameter int DW = 256,
    parameter int AW = 64,
    parameter int CW = 32
);
    logic [N-1:0]    uhost_req_valid;
    logic [N*CW-1:0] uhost_req_cmd;
    logic [N*AW-1:0] uhost_req_dstaddr;
    logic [N*AW-1:0] uhost_req_srcaddr;
    logic [N*DW-1:0] uhost_req_data;
    logic [N-1:0]    uhost_req_ready;

    logic [N-1:0]    uhost_resp_valid;
    logic [CW-1:0]   uhost_resp_cmd;
    logic [AW-1:0]   uhost_resp_dstaddr;
    logic [AW-1:0]   uhost_resp_srcaddr;
    logic [DW-1:0]   uhost_resp_data;
    logic [N-1:0]    uhost_resp_ready;

    logic            udev_req_valid;
    logic [CW-1:0]   udev_req_cmd;
    logic [AW-1:0]   udev_req_dstaddr;
    logic [AW-1:0]   udev_req_srcaddr;
    logic [DW-1:0]   udev_req_data;
    logic            udev_req_ready;

    logic            udev_resp_valid;
    logic [CW-1:0]   udev_resp_cmd;
    logic [AW-1:0]   udev_resp_dstaddr;
    logic [AW-1:0]   udev_resp_srcaddr;
    logic [DW-1:0]   udev_resp_data;
    logic            udev_resp_ready;

    modport slave (
        input  uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data,
        output uhost_req_ready,
        output uhost_resp_valid, uhost_resp_cmd, uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data,
        input  uhost_resp_ready,
        output udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        input  udev_req_ready,
        input  udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data,
        output udev_resp_ready
    );

    modport master (
        output uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data,
        input  uhost_req_ready,
        input  uhost_resp_valid, uhost_resp_cmd, uhost_resp_dstaddr, uhost_resp_srcaddr, uhost_resp_data,
        output uhost_resp_ready,
        input  udev_req_valid, udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr, udev_req_data,
        output udev_req_ready,
        output udev_resp_valid, udev_resp_cmd, udev_resp_dstaddr, udev_resp_srcaddr, udev_resp_data,
        input  udev_resp_ready
    );
endinterface

// File: rtl/umi_req_arbiter.sv
// Round-robin, message-granular sharing of one in-order UMI device among N hosts; responses routed by an in-order tag FIFO.
// Zero-cycle request and response paths; a full tag FIFO stalls the round-robin head at message start, device ready passes through.
module umi_req_arbiter #(
    parameter int N     = 2,
    parameter int DW    = 256,
    parameter int AW    = 64,
    parameter int CW    = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    umi_req_arbiter_if.slave u
);
    localparam int NW   = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [4:0] OP_READ  = 5'h01;
    localparam logic [4:0] OP_WRITE = 5'h03;

    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    state_t          state, state_nxt;
    logic [NW-1:0]   lock_id, lock_id_nxt;
    logic [NW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NW-1:0]   cand, grant, head;
    logic [NW:0]     sum;
    logic [CW-1:0]   gcmd;
    logic            expects, full, empty, gate_open;
    logic            req_acc, push, pop;
    logic [N-1:0]    req_rdy, resp_vld;
    logic [NW-1:0]   tag_mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;

    // Walk downward from the farthest candidate so the host nearest rr_ptr wins.
    always_comb begin
        cand = rr_ptr;
        sum  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (NW+1)'(k);
            if (sum >= (NW+1)'(N)) sum = sum - (NW+1)'(N);
            if (u.uhost_req_valid[sum[NW-1:0]]) cand = sum[NW-1:0];
        end
    end

    assign grant   = (state == ST_LOCK) ? lock_id : cand;
    assign gcmd    = u.uhost_req_cmd[int'(grant)*CW +: CW];
    assign expects = (gcmd[4:0] == OP_READ) || (gcmd[4:0] == OP_WRITE);
    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);

    // Only a message start can be held off; continuation flits never allocate a tag.
    assign gate_open = !rst && ((state == ST_LOCK) || !(expects && full));

    always_comb begin
        req_rdy        = '0;
        req_rdy[grant] = u.udev_req_ready && gate_open;
    end

    assign u.uhost_req_ready  = req_rdy;
    assign u.udev_req_valid   = u.uhost_req_valid[grant] && gate_open;
    assign u.udev_req_cmd     = gcmd;
    assign u.udev_req_dstaddr = u.uhost_req_dstaddr[int'(grant)*AW +: AW];
    assign u.udev_req_srcaddr = u.uhost_req_srcaddr[int'(grant)*AW +: AW];
    assign u.udev_req_data    = u.uhost_req_data[int'(grant)*DW +: DW];

    assign req_acc = u.udev_req_valid && u.udev_req_ready;
    assign push    = req_acc && (state == ST_IDLE) && expects;

    always_comb begin
        state_nxt   = state;
        lock_id_nxt = lock_id;
        rr_ptr_nxt  = rr_ptr;
        if (req_acc) begin
            if (!gcmd[22]) begin
                state_nxt   = ST_LOCK;
                lock_id_nxt = grant;
            end else begin
                state_nxt  = ST_IDLE;
                rr_ptr_nxt = (grant == NW'(N - 1)) ? '0 : grant + NW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            lock_id <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            lock_id <= lock_id_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

    // Response routing: the head tag owns every flit up to and including the eom flit.
    assign head = tag_mem[rd_ptr];

    always_comb begin
        resp_vld = '0;
        if (!empty) resp_vld[head] = u.udev_resp_valid;
    end

    assign u.uhost_resp_valid   = resp_vld;
    assign u.udev_resp_ready    = !empty && u.uhost_resp_ready[head];
    assign u.uhost_resp_cmd     = u.udev_resp_cmd;
    assign u.uhost_resp_dstaddr = u.udev_resp_dstaddr;
    assign u.uhost_resp_srcaddr = u.udev_resp_srcaddr;
    assign u.uhost_resp_data    = u.udev_resp_data;

    assign pop = u.udev_resp_valid && u.udev_resp_ready && u.udev_resp_cmd[22];

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_umi_req_arbiter.sv
// Directed vector table plus hand-written multi-cycle sequences for the UMI request arbiter (N=2, DEPTH=4).
module tb_umi_req_arbiter;
    localparam int N = 2, DW = 256, AW = 64, CW = 32, DEPTH = 4;
    localparam logic [4:0] R = 5'h01, W = 5'h03, P = 5'h05, X = 5'h07;
    localparam logic [DW-1:0] D0 = {8{32'hA0A0_1234}};
    localparam logic [DW-1:0] D1 = {8{32'hB1B1_5678}};
    localparam logic [DW-1:0] RD = {8{32'hC3C3_9ABC}};

    logic clk, rst;
    int   n_cmp = 0, n_bad = 0;

    umi_req_arbiter_if #(.N(N), .DW(DW), .AW(AW), .CW(CW)) bus ();

    umi_req_arbiter #(.N(N), .DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .u   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] hv;
        logic [4:0] op0;
        logic       e0;
        logic [4:0] op1;
        logic       e1;
        logic       drdy;
        logic       rv;
        logic       reom;
        logic [1:0] hrr;
        logic       x_dv;
        logic [1:0] x_hr;
        logic       x_g;
        logic [1:0] x_hrv;
        logic       x_drr;
        logic [2:0] x_cnt;
    } vec_t;

    vec_t vt [26];

    function automatic logic [CW-1:0] mkcmd(input logic [4:0] op, input logic eom, input int id);
        logic [CW-1:0] c;
        c       = '0;
        c[4:0]  = op;
        c[22]   = eom;
        c[15:8] = 8'(id) + 8'h10;
        return c;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] hv, input logic [4:0] op0, input logic e0,
                         input logic [4:0] op1, input logic e1, input logic drdy,
                         input logic rv, input logic reom, input logic [1:0] hrr);
        bus.uhost_req_valid           = hv;
        bus.uhost_req_cmd[0*CW +: CW] = mkcmd(op0, e0, 0);
        bus.uhost_req_cmd[1*CW +: CW] = mkcmd(op1, e1, 1);
        bus.udev_req_ready            = drdy;
        bus.udev_resp_valid           = rv;
        bus.udev_resp_cmd             = mkcmd(R, reom, 7);
        bus.uhost_resp_ready          = hrr;
    endtask

    initial begin
        // hv, op0,e0, op1,e1, drdy, rv,reom, hrr | dv, hr, g, hrv, drr, cnt
        vt[0]  = '{2'b11, P,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[1]  = '{2'b11, P,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 3'd0};
        vt[2]  = '{2'b11, P,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[3]  = '{2'b11, P,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 3'd0};
        vt[4]  = '{2'b11, W,1'b0, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[5]  = '{2'b11, W,1'b0, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 3'd1};
        vt[6]  = '{2'b11, W,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 3'd1};
        vt[7]  = '{2'b11, P,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b00, 1'b1, 3'd1};
        vt[8]  = '{2'b00, P,1'b1, P,1'b1, 1'b0, 1'b1,1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 3'd1};
        vt[9]  = '{2'b10, P,1'b1, R,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 3'd0};
        vt[10] = '{2'b01, R,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 3'd1};
        vt[11] = '{2'b00, P,1'b1, P,1'b1, 1'b0, 1'b1,1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'd2};
        vt[12] = '{2'b00, P,1'b1, P,1'b1, 1'b0, 1'b1,1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'd2};
        vt[13] = '{2'b00, P,1'b1, P,1'b1, 1'b0, 1'b1,1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 3'd1};
        vt[14] = '{2'b00, P,1'b1, P,1'b1, 1'b0, 1'b0,1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[15] = '{2'b01, R,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[16] = '{2'b00, P,1'b1, P,1'b1, 1'b0, 1'b1,1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 3'd1};
        vt[17] = '{2'b10, P,1'b1, R,1'b1, 1'b1, 1'b1,1'b1, 2'b11, 1'b1, 2'b10, 1'b1, 2'b01, 1'b1, 3'd1};
        vt[18] = '{2'b00, P,1'b1, P,1'b1, 1'b0, 1'b0,1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'd1};
        vt[19] = '{2'b00, P,1'b1, P,1'b1, 1'b0, 1'b1,1'b1, 2'b11, 1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 3'd1};
        vt[20] = '{2'b01, X,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[21] = '{2'b00, P,1'b1, P,1'b1, 1'b0, 1'b0,1'b0, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[22] = '{2'b01, P,1'b0, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[23] = '{2'b10, P,1'b0, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[24] = '{2'b11, P,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 3'd0};
        vt[25] = '{2'b11, P,1'b1, P,1'b1, 1'b1, 1'b0,1'b0, 2'b11, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 3'd0};

        bus.uhost_req_dstaddr = {64'h2000, 64'h1000};
        bus.uhost_req_srcaddr = {64'h0020, 64'h0010};
        bus.uhost_req_data    = {D1, D0};
        bus.udev_resp_dstaddr = 64'h0010;
        bus.udev_resp_srcaddr = 64'h1000;
        bus.udev_resp_data    = RD;

        // Reset holds every handshake output low even with live inputs.
        rst = 1'b1;
        drive(2'b11, R, 1'b1, R, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
        #2;
        chk("rst_dv",  0, bus.udev_req_valid, 0);
        chk("rst_hr",  0, bus.uhost_req_ready, 0);
        chk("rst_hrv", 0, bus.uhost_resp_valid, 0);
        chk("rst_drr", 0, bus.udev_resp_ready, 0);
        chk("rst_cnt", 0, dut.count, 0);
        @(negedge clk);
        drive(2'b00, P, 1'b1, P, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        rst = 1'b0;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            drive(vt[i].hv, vt[i].op0, vt[i].e0, vt[i].op1, vt[i].e1,
                  vt[i].drdy, vt[i].rv, vt[i].reom, vt[i].hrr);
            #2;
            chk("dv",  i, bus.udev_req_valid,   vt[i].x_dv);
            chk("hr",  i, bus.uhost_req_ready,  vt[i].x_hr);
            chk("hrv", i, bus.uhost_resp_valid, vt[i].x_hrv);
            chk("drr", i, bus.udev_resp_ready,  vt[i].x_drr);
            chk("cnt", i, dut.count,            vt[i].x_cnt);
            if (vt[i].x_dv) begin
                chk("req_data", i, bus.udev_req_data, vt[i].x_g ? D1 : D0);
                chk("req_cmd",  i, bus.udev_req_cmd,
                    vt[i].x_g ? mkcmd(vt[i].op1, vt[i].e1, 1) : mkcmd(vt[i].op0, vt[i].e0, 0));
            end
            if (vt[i].rv) begin
                chk("resp_data", i, bus.uhost_resp_data, RD);
                chk("resp_cmd",  i, bus.uhost_resp_cmd, mkcmd(R, vt[i].reom, 7));
            end
        end

        // Full tag FIFO: four READs fill it, the fifth waits for one eom response.
        @(negedge clk);
        drive(2'b11, R, 1'b1, R, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("fill_hr",  100 + k, bus.uhost_req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("fill_cnt", 100 + k, dut.count, k);
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("full_dv",  110 + k, bus.udev_req_valid, 0);
            chk("full_hr",  110 + k, bus.uhost_req_ready, 0);
            chk("full_cnt", 110 + k, dut.count, 4);
            @(negedge clk);
        end
        bus.udev_resp_valid = 1'b1;
        bus.udev_resp_cmd   = mkcmd(R, 1'b1, 7);
        #2;
        chk("full_pop_hrv", 120, bus.uhost_resp_valid, 2'b01);
        chk("full_pop_drr", 120, bus.udev_resp_ready, 1);
        @(negedge clk);
        bus.udev_resp_valid = 1'b0;
        #2;
        chk("fifth_cnt", 121, dut.count, 3);
        chk("fifth_dv",  121, bus.udev_req_valid, 1);
        chk("fifth_hr",  121, bus.uhost_req_ready, 2'b01);
        @(negedge clk);
        drive(2'b00, P, 1'b1, P, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        #2;
        chk("refill_cnt", 122, dut.count, 4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(2'b00, P, 1'b1, P, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11);
            #2;
            chk("drain_hrv", 130 + k, bus.uhost_resp_valid, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        @(negedge clk);
        bus.udev_resp_valid = 1'b0;
        #2;
        chk("drain_cnt", 134, dut.count, 0);

        // Reset while host0 is locked with two tags queued.
        @(negedge clk);
        drive(2'b10, P, 1'b1, R, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
        #2;
        chk("pre_h1_hr", 140, bus.uhost_req_ready, 2'b10);
        @(negedge clk);
        drive(2'b01, W, 1'b0, R, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
        #2;
        chk("pre_h0_hr", 141, bus.uhost_req_ready, 2'b01);
        @(negedge clk);
        drive(2'b11, W, 1'b0, R, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
        #2;
        chk("lock_hr",  142, bus.uhost_req_ready, 2'b01);
        chk("lock_cnt", 142, dut.count, 2);
        chk("lock_hrv", 142, bus.uhost_resp_valid, 2'b10);
        #1 rst = 1'b1;
        #1;
        chk("arst_dv",  143, bus.udev_req_valid, 0);
        chk("arst_hr",  143, bus.uhost_req_ready, 0);
        chk("arst_hrv", 143, bus.uhost_resp_valid, 0);
        chk("arst_drr", 143, bus.udev_resp_ready, 0);
        chk("arst_cnt", 143, dut.count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b10, W, 1'b0, R, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11);
        #2;
        chk("post_dv",  144, bus.udev_req_valid, 1);
        chk("post_hr",  144, bus.uhost_req_ready, 2'b10);
        chk("post_dat", 144, bus.udev_req_data, D1);
        chk("post_hrv", 144, bus.uhost_resp_valid, 0);
        chk("post_drr", 144, bus.udev_resp_ready, 0);
        @(negedge clk);
        drive(2'b00, P, 1'b1, P, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
        #2;
        chk("post_cnt", 145, dut.count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/umi_req_arbiter.md
Name: umi_req_arbiter

Overview:
- Shares one UMI device port (e.g. a GPIO or register endpoint) between N UMI hosts.
- Round-robin arbitration happens at message granularity on the request channel.
- Each response-expecting request gets its requester ID pushed into an in-order tag FIFO, which routes device responses back to the originating host.
- Sits between host-side request muxes and a single in-order UMI device.

Parameters:
- N, 2, number of requesters (2..8)
- DW, 256, UMI data width
- AW, 64, UMI address width
- CW, 32, UMI command width
- DEPTH, 4, outstanding response-expecting messages tracked (power of 2, ≥2)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- uhost_req_valid  input  N  per-host request valid
- uhost_req_cmd  input  N*CW  host i at [i*CW +: CW]
- uhost_req_dstaddr  input  N*AW  packed per host
- uhost_req_srcaddr  input  N*AW  packed per host
- uhost_req_data  input  N*DW  packed per host
- uhost_req_ready  output  N  per-host request ready
- uhost_resp_valid  output  N  per-host response valid
- uhost_resp_cmd  output  CW  broadcast to all hosts
- uhost_resp_dstaddr  output  AW  broadcast
- uhost_resp_srcaddr  output  AW  broadcast
- uhost_resp_data  output  DW  broadcast
- uhost_resp_ready  input  N  per-host response ready
- udev_req_valid/cmd/dstaddr/srcaddr/data  output  1/CW/AW/AW/DW  to device
- udev_req_ready  input  1
- udev_resp_valid/cmd/dstaddr/srcaddr/data  input  1/CW/AW/AW/DW  from device
- udev_resp_ready  output  1

Behaviour:
- Reset: rst is async and active-high.
  - While rst is high and on release: lock=0, rr_ptr=0, tag FIFO empty (count=0).
  - All uhost_req_ready=0, uhost_resp_valid=0, udev_req_valid=0, udev_resp_ready=0.
  - Reset mid-message discards lock and all tags. Device-side flush is the system's responsibility.
- Command decode: fields come from umi_unpack.
  - Opcode is cmd[4:0]; eom is cmd[22].
  - READ=5'h01 and WRITE=5'h03 expect a response; POSTED=5'h05 does not.
  - All other opcodes are forwarded as posted.
- Request path is combinational with zero latency. Flits pass unmodified from the granted host.
- Grant:
  - If lock=1, grant = locked host.
  - Otherwise, grant = first host with valid, searching from rr_ptr upward, modulo N.
- Message start (lock=0) gate:
  - If the granted flit expects a response and count==DEPTH, withhold udev_req_valid and the host's ready.
  - Other hosts are not granted while the head candidate is stalled. This preserves strict round-robin.
- udev_req_valid = granted host valid AND gate open. uhost_req_ready[g] = udev_req_ready AND gate open; all other readies are 0.
- On an accepted flit:
  - If lock=0 and the flit expects a response: push g into the tag FIFO.
  - If eom=0: set lock=1 and locked host = g.
  - If eom=1: set lock=0 and rr_ptr = (g+1) mod N.
  - Single-flit messages never lock.
- Response path is combinational with zero latency.
  - head = FIFO head.
  - uhost_resp_valid[head] = udev_resp_valid AND count≠0.
  - udev_resp_ready = uhost_resp_ready[head] AND count≠0.
  - Response fields are broadcast unmodified.
- Pop the FIFO on a response handshake with resp eom=1. Non-eom flits keep the head, so multi-flit read responses all go to one host.
- Response arriving with count==0: udev_resp_ready=0 and the device stalls. This is a protocol error and must never occur in a legal system.
- Same-cycle push and pop:
  - Both take effect; count is unchanged.
  - When full, push is gated at message start as above; no bypass.
- FIFO: DEPTH entries of clog2(N) bits. Read and write pointers wrap mod DEPTH. count width is clog2(DEPTH+1).
- A host's request valid may drop mid-message. Lock holds and no other host is granted until that host's eom flit is accepted.

Test Plan:
- Round-robin:
  - Stimulus: N=2, both hosts continuously send single-flit POSTED; udev_req_ready=1.
  - Required response: grants alternate 0,1,0,1; FIFO count stays 0.
- Locking:
  - Stimulus: host0 sends 3-flit WRITE (eom on flit 3) while host1 is valid.
  - Required response: host0 gets 3 consecutive grants; host1 is granted next; exactly one tag (0) is pushed.
- Response routing:
  - Stimulus: host1 READ, then host0 READ; device returns a 2-flit response then a 1-flit response.
  - Required response: both host1 flits are delivered only to host1, then host0 gets its flit; count returns to 0.
- Full FIFO:
  - Stimulus: DEPTH=4; hosts issue 5 READs with device responses held off.
  - Required response: the 5th stalls with uhost_req_ready=0. After one eom response handshake, the 5th is accepted in the same or next cycle.
- Backpressure and simultaneous push/pop:
  - Stimulus: deassert uhost_resp_ready[head] while udev_resp_valid=1; meanwhile a new READ is accepted in the same cycle a response eom pops.
  - Required response: udev_resp_ready=0 while the head host is not ready; count is unchanged across the simultaneous push and pop.
- Reset mid-message:
  - Stimulus: assert rst while host0 is locked with 2 tags queued.
  - Required response: outputs go to reset values immediately (asynchronously); after release, host1 can be granted first.
